// File: rtl/mult_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM states, multiplier mode encoding
// and a small index helper used by round-robin logic.
package mult_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      MODE_UNSIGNED        = 2'b00,
      MODE_SIGNED_UNSIGNED = 2'b01,
      MODE_SIGNED          = 2'b10,
      MODE_UNSIGNED_SIGNED = 2'b11
   } mult_mode_t;

   // Increment an index and wrap it back to zero at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: searches upward from the
// pointer, wrapping, and returns a one-hot grant plus its index.
module rr_pick
   import mult_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PW-1:0]      o_idx,
   output logic               o_valid
);

   logic [PW-1:0] w_cand;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand = PW'((int'(i_ptr) + i) % NUM_REQ);
         if (!o_valid && i_req[w_cand]) begin
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
            o_valid         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between NUM_REQ requesters.
// Optional watchdog on the multiplier handshake: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 128
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0][1:0]         req_mode,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_multiplicand,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_multiplier,
   output logic [NUM_REQ-1:0]              ack,
   output logic [NUM_REQ-1:0]              resp_valid,
   output logic [WIDTH-1:0]                resp_result,
`ifdef MULT_ARB_TIMEOUT_EN
   output logic                            resp_err,
`endif
   output logic                            busy,
   output logic                            mul_start,
   output logic [1:0]                      mul_mode,
   output logic [WIDTH-1:0]                mul_multiplicand,
   output logic [WIDTH-1:0]                mul_multiplier,
   input  logic [WIDTH-1:0]                mul_result,
   input  logic                            mul_done
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES positive");
   end

   arb_state_t           r_state;
   arb_state_t           w_next_state;
   logic [NUM_REQ-1:0]   w_grant;
   logic [PW-1:0]        w_idx;
   logic                 w_pick_valid;
   logic                 w_timeout;

   logic [PW-1:0]        r_ptr;
   logic [PW-1:0]        r_idx;
   logic [NUM_REQ-1:0]   r_grant;
   logic [NUM_REQ-1:0]   r_ack;
   logic [NUM_REQ-1:0]   r_resp_valid;
   logic [WIDTH-1:0]     r_resp_result;
   logic                 r_busy;
   logic                 r_mul_start;
   mult_mode_t           r_mode;
   logic [WIDTH-1:0]     r_multiplicand;
   logic [WIDTH-1:0]     r_multiplier;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_pick_valid)
   );

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_err;

   // Fires on the WAIT cycle in which the count would reach TIMEOUT_CYCLES.
   assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wait_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign resp_err = r_err;
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_next_state = ISSUE;
         ISSUE:   w_next_state = WAIT;
         WAIT:    if (mul_done || w_timeout) w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Pulses default low each cycle; latched operands only change on a new grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr          <= '0;
         r_idx          <= '0;
         r_grant        <= '0;
         r_ack          <= '0;
         r_resp_valid   <= '0;
         r_resp_result  <= '0;
         r_busy         <= 1'b0;
         r_mul_start    <= 1'b0;
         r_mode         <= MODE_UNSIGNED;
         r_multiplicand <= '0;
         r_multiplier   <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
         r_err          <= 1'b0;
`endif
      end else begin
         r_ack        <= '0;
         r_resp_valid <= '0;
         r_mul_start  <= 1'b0;
         r_busy       <= (w_next_state != IDLE);
`ifdef MULT_ARB_TIMEOUT_EN
         r_err        <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_grant        <= w_grant;
                  r_idx          <= w_idx;
                  r_mode         <= mult_mode_t'(req_mode[w_idx]);
                  r_multiplicand <= req_multiplicand[w_idx];
                  r_multiplier   <= req_multiplier[w_idx];
                  r_ack          <= w_grant;
                  r_mul_start    <= 1'b1;
               end
            end
            WAIT: begin
               if (mul_done) begin
                  r_resp_result <= mul_result;
                  r_resp_valid  <= r_grant;
               end else if (w_timeout) begin
                  r_resp_result <= '0;
                  r_resp_valid  <= r_grant;
`ifdef MULT_ARB_TIMEOUT_EN
                  r_err         <= 1'b1;
`endif
               end
            end
            RESP: begin
               r_ptr <= PW'(wrap_inc(int'(r_idx), NUM_REQ));
            end
            default: begin
            end
         endcase
      end
   end

   assign ack              = r_ack;
   assign resp_valid       = r_resp_valid;
   assign resp_result      = r_resp_result;
   assign busy             = r_busy;
   assign mul_start        = r_mul_start;
   assign mul_mode         = r_mode;
   assign mul_multiplicand = r_multiplicand;
   assign mul_multiplier   = r_multiplier;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: directed transactions push expected
// accepts/results, a negedge monitor pops and compares what the DUT presents.
module tb_mult_arbiter;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0][1:0]       reqMode;
   logic [NUM_REQ-1:0][WIDTH-1:0] reqA;
   logic [NUM_REQ-1:0][WIDTH-1:0] reqB;
   logic [NUM_REQ-1:0]            ack;
   logic [NUM_REQ-1:0]            respValid;
   logic [WIDTH-1:0]              respResult;
   logic                          busy;
   logic                          mulStart;
   logic [1:0]                    mulMode;
   logic [WIDTH-1:0]              mulA;
   logic [WIDTH-1:0]              mulB;
   logic [WIDTH-1:0]              mulResult = '0;
   logic                          mulDone   = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
   logic                          respErr;
`endif

   typedef struct {
      logic [1:0]       grant;
      logic [1:0]       mode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } ackExp_t;

   typedef struct {
      logic [1:0]       grant;
      logic [WIDTH-1:0] result;
   } respExp_t;

   ackExp_t  ackQ[$];
   respExp_t respQ[$];

   int nChecks = 0;
   int nFails  = 0;
   int reqWanted[NUM_REQ];
   int reqSeen[NUM_REQ];
   int mulCnt = 0;
   int mulLatency = 3;
   logic [WIDTH-1:0] mulRes = '0;
   logic lastDone = 1'b0;

   // Each requester holds req high until it has seen as many accepts as it asked for.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign req[g] = (reqWanted[g] != reqSeen[g]);
   end

   mult_arbiter #(
      .WIDTH          (WIDTH),
      .NUM_REQ        (NUM_REQ),
      .TIMEOUT_CYCLES (128)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req              (req),
      .req_mode         (reqMode),
      .req_multiplicand (reqA),
      .req_multiplier   (reqB),
      .ack              (ack),
      .resp_valid       (respValid),
      .resp_result      (respResult),
`ifdef MULT_ARB_TIMEOUT_EN
      .resp_err         (respErr),
`endif
      .busy             (busy),
      .mul_start        (mulStart),
      .mul_mode         (mulMode),
      .mul_multiplicand (mulA),
      .mul_multiplier   (mulB),
      .mul_result       (mulResult),
      .mul_done         (mulDone)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [1:0] mode, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input int reps);
      reqMode[idx]   = mode;
      reqA[idx]      = a;
      reqB[idx]      = b;
      reqWanted[idx] = reqWanted[idx] + reps;
   endtask

   task automatic expectTxn(input logic [1:0] grant, input logic [1:0] mode, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] result, input bit withResp);
      ackQ.push_back('{grant, mode, a, b});
      if (withResp) respQ.push_back('{grant, result});
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while ((busy || req != 0 || ackQ.size() != 0 || respQ.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " drained"}, 32'(n < 300), 1);
      @(negedge clk);
   endtask

   // Multiplier model: fixed latency after mul_start, truncated product.
   always @(posedge clk) begin
      #1;
      mulDone = 1'b0;
      if (!reset) begin
         mulCnt = 0;
      end else if (mulStart) begin
         mulCnt = mulLatency;
         mulRes = WIDTH'(mulA * mulB);
      end else if (mulCnt > 0) begin
         mulCnt--;
         if (mulCnt == 0) begin
            mulDone   = 1'b1;
            mulResult = mulRes;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if (mulStart || ack != 0)
            checkOutput("mul_start with ack", 32'(mulStart), 32'(ack != 0));
         if (ack != 0) begin
            for (int i = 0; i < NUM_REQ; i++)
               if (ack[i]) reqSeen[i]++;
            if (ackQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected ack: actual=%0b required=none", ack);
            end else begin
               ackExp_t e;
               e = ackQ.pop_front();
               checkOutput("ack grant", ack, e.grant);
               checkOutput("mul_mode", mulMode, e.mode);
               checkOutput("mul_multiplicand", mulA, e.a);
               checkOutput("mul_multiplier", mulB, e.b);
            end
         end
         if (respValid != 0) begin
            if (respQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected resp_valid: actual=%0b required=none", respValid);
            end else begin
               respExp_t r;
               r = respQ.pop_front();
               checkOutput("resp one cycle after done", lastDone, 1);
               checkOutput("resp_valid grant", respValid, r.grant);
               checkOutput("resp_result", respResult, r.result);
            end
         end
      end
      lastDone = mulDone;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reqMode = '0;
      reqA    = '0;
      reqB    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         reqWanted[i] = 0;
         reqSeen[i]   = 0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] reset state");
      checkOutput("reset ack", ack, 0);
      checkOutput("reset resp_valid", respValid, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset mul_start", mulStart, 0);
      checkOutput("reset resp_result", respResult, 0);
      checkOutput("reset mul_mode", mulMode, 0);
      checkOutput("reset mul_multiplicand", mulA, 0);
      checkOutput("reset mul_multiplier", mulB, 0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] single request");
      expectTxn(2'b01, 2'b10, 8'd5, 8'd12, 8'd60, 1'b1);
      applyStimulus(0, 2'b10, 8'd5, 8'd12, 1);
      @(negedge clk);
      checkOutput("single ack latency", ack, 2'b01);
      checkOutput("single busy", busy, 1);
      waitIdle("single");

      $display("[TB] reset mid-WAIT");
      expectTxn(2'b10, 2'b01, 8'd2, 8'd3, 8'd6, 1'b0);
      applyStimulus(1, 2'b01, 8'd2, 8'd3, 1);
      @(negedge clk);
      checkOutput("abort ack", ack, 2'b10);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort ack cleared", ack, 0);
      checkOutput("abort mul_start", mulStart, 0);
      checkOutput("abort mul_multiplicand", mulA, 0);
      checkOutput("abort mul_multiplier", mulB, 0);
      checkOutput("abort mul_mode", mulMode, 0);
      checkOutput("abort resp_result", respResult, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("abort stays idle", busy, 0);
      expectTxn(2'b10, 2'b11, 8'd9, 8'd9, 8'd81, 1'b1);
      applyStimulus(1, 2'b11, 8'd9, 8'd9, 1);
      waitIdle("after reset");

      $display("[TB] simultaneous requests");
      expectTxn(2'b01, 2'b00, 8'd3, 8'd4, 8'd12, 1'b1);
      expectTxn(2'b10, 2'b00, 8'd6, 8'd7, 8'd42, 1'b1);
      applyStimulus(0, 2'b00, 8'd3, 8'd4, 1);
      applyStimulus(1, 2'b00, 8'd6, 8'd7, 1);
      waitIdle("simultaneous");

      $display("[TB] fairness");
      expectTxn(2'b01, 2'b00, 8'd2, 8'd10, 8'd20, 1'b1);
      expectTxn(2'b10, 2'b01, 8'd3, 8'd10, 8'd30, 1'b1);
      expectTxn(2'b01, 2'b00, 8'd2, 8'd10, 8'd20, 1'b1);
      expectTxn(2'b10, 2'b01, 8'd3, 8'd10, 8'd30, 1'b1);
      applyStimulus(0, 2'b00, 8'd2, 8'd10, 2);
      applyStimulus(1, 2'b01, 8'd3, 8'd10, 2);
      waitIdle("fairness");

      $display("[TB] busy hold-off");
      expectTxn(2'b01, 2'b01, 8'd7, 8'd8, 8'd56, 1'b1);
      expectTxn(2'b10, 2'b10, 8'd11, 8'd11, 8'd121, 1'b1);
      applyStimulus(0, 2'b01, 8'd7, 8'd8, 1);
      @(negedge clk);
      @(negedge clk);
      applyStimulus(1, 2'b10, 8'd11, 8'd11, 1);
      n = 0;
      while (respValid == 0 && n < 50) begin
         checkOutput("holdoff busy", busy, 1);
         checkOutput("holdoff no ack", ack, 0);
         @(negedge clk);
         n++;
      end
      checkOutput("holdoff resp seen", 32'(n < 50), 1);
      @(negedge clk);
      checkOutput("holdoff idle busy", busy, 0);
      checkOutput("holdoff idle ack", ack, 0);
      @(negedge clk);
      checkOutput("holdoff req1 ack", ack, 2'b10);
      waitIdle("holdoff");

      checkOutput("ack queue empty", ackQ.size(), 0);
      checkOutput("resp queue empty", respQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
